// File: rtl/systolic_pkg.sv
// =============================================================================
//  Module      : systolic_pkg
//  Description : Shared constants and types for the 6x6 systolic array feeder:
//                lane geometry, Q6.10 word format, feeder FSM state encoding
//                and the packed activation lane vector.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package systolic_pkg;

   localparam int WIDTH    = 16;   // lane word width, signed Q6.10
   localparam int FRAC_BIT = 10;   // binary point position of a lane word
   localparam int LANES    = 6;    // activation lanes into the array

   // Feeder sequencing: one clear cycle, the data beats, a zero flush that
   // drains the array, then a one-cycle completion marker.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      STREAM = 3'd2,
      FLUSH  = 3'd3,
      DONE   = 3'd4
   } feeder_state_t;

   // Lane k occupies bits [k*WIDTH +: WIDTH].
   typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

endpackage : systolic_pkg

`default_nettype wire

// File: rtl/systolic_lane_delay.sv
// =============================================================================
//  Module      : systolic_lane_delay
//  Description : Enable-gated shift register of DEPTH words with synchronous
//                clear. Used to skew one activation lane so the array sees a
//                diagonal wavefront.
//  Ports       : clk, rst   - clock / synchronous active-high reset
//                i_clr      - synchronous clear of all stages
//                i_en       - shift strobe
//                i_d / o_q  - lane word in / delayed lane word out
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module systolic_lane_delay #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 1      // must be >= 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_pipe <= '0;
      end else if (i_en) begin
         r_pipe[0] <= i_d;
         for (int i = 1; i < DEPTH; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end
   end

   assign o_q = r_pipe[DEPTH-1];

endmodule : systolic_lane_delay

`default_nettype wire

// File: rtl/systolic_6x6_feeder.sv
// =============================================================================
//  Module      : systolic_6x6_feeder
//  Description : Stream-side transmitter for the 6x6 systolic array. Accepts
//                6-lane activation beats over valid/ready and produces the
//                array drive (a0..a5, en, clr): clear, beats, zero flush, done.
//  Ports       : clk, rst             - clock / synchronous active-high reset
//                s_valid/s_ready/s_last/s_data - input beat stream
//                a0..a5, en, clr      - registered array drive
//                busy, batch_done     - status; done is a one-cycle pulse
//                beat_cnt             - beats accepted in current/last batch
//                err_overlen          - sticky: MAX_LEN hit without s_last
//  Options     : SYSTOLIC_FEEDER_SKEW_EN - delay lane k by k extra en-cycles
//                and lengthen the flush by LANES-1 cycles.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module systolic_6x6_feeder
   import systolic_pkg::*;
#(
   parameter int WIDTH        = 16,
   parameter int FLUSH_CYCLES = 14,   // 1..255
   parameter int MAX_LEN      = 16    // 1..255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic                   s_last,
   input  logic [LANES*WIDTH-1:0] s_data,
   output logic [WIDTH-1:0]       a0,
   output logic [WIDTH-1:0]       a1,
   output logic [WIDTH-1:0]       a2,
   output logic [WIDTH-1:0]       a3,
   output logic [WIDTH-1:0]       a4,
   output logic [WIDTH-1:0]       a5,
   output logic                   en,
   output logic                   clr,
   output logic                   busy,
   output logic                   batch_done,
   output logic [7:0]             beat_cnt,
   output logic                   err_overlen
);

`ifdef SYSTOLIC_FEEDER_SKEW_EN
   localparam int c_SKEW_DEPTH = LANES - 1;
`else
   localparam int c_SKEW_DEPTH = 0;
`endif
   // Flush counter is loaded with (length-1) and counts down to zero.
   localparam logic [8:0] c_FLUSH_LOAD = 9'(FLUSH_CYCLES + c_SKEW_DEPTH - 1);
   localparam logic [7:0] c_MAX_LEN    = 8'(MAX_LEN);

   feeder_state_t                r_state;
   logic [LANES-1:0][WIDTH-1:0]  r_a;
   logic [LANES-1:0][WIDTH-1:0]  w_a_out;
   logic                         r_en;
   logic                         r_clr;
   logic                         r_done;
   logic                         r_err;
   logic [7:0]                   r_beat_cnt;
   logic [8:0]                   r_flush_cnt;
   logic                         w_accept;
   logic [7:0]                   w_cnt_next;

   assign s_ready    = (r_state == STREAM);
   assign w_accept   = s_valid && s_ready;
   assign w_cnt_next = r_beat_cnt + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_en        <= 1'b0;
         r_clr       <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_beat_cnt  <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_clr  <= 1'b0;
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_en <= 1'b0;
               r_a  <= '0;
               // The waiting beat stays on the bus; it is consumed in STREAM.
               if (s_valid) begin
                  r_state <= CLEAR;
                  r_clr   <= 1'b1;
               end
            end
            CLEAR: begin
               r_en       <= 1'b0;
               r_beat_cnt <= '0;
               r_state    <= STREAM;
            end
            STREAM: begin
               if (w_accept) begin
                  r_a        <= s_data;
                  r_en       <= 1'b1;
                  r_beat_cnt <= w_cnt_next;
                  if (s_last) begin
                     r_state     <= FLUSH;
                     r_flush_cnt <= c_FLUSH_LOAD;
                  end else if (w_cnt_next == c_MAX_LEN) begin
                     r_err       <= 1'b1;
                     r_state     <= FLUSH;
                     r_flush_cnt <= c_FLUSH_LOAD;
                  end
               end else begin
                  // Bubble: array freezes, lane words hold.
                  r_en <= 1'b0;
               end
            end
            FLUSH: begin
               r_a  <= '0;
               r_en <= 1'b1;
               if (r_flush_cnt == 9'd0) begin
                  r_state <= DONE;
               end else begin
                  r_flush_cnt <= r_flush_cnt - 9'd1;
               end
            end
            DONE: begin
               r_a     <= '0;
               r_en    <= 1'b0;
               r_done  <= 1'b1;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef SYSTOLIC_FEEDER_SKEW_EN
   // Skew stages advance on the same edge that loads r_a for an en=1 cycle,
   // so during a bubble every lane (delayed or not) holds its word.
   logic w_shift;
   assign w_shift    = w_accept || (r_state == FLUSH);
   assign w_a_out[0] = r_a[0];
   for (genvar k = 1; k < LANES; k++) begin : g_skew
      systolic_lane_delay #(
         .WIDTH (WIDTH),
         .DEPTH (k)
      ) u_delay (
         .clk   (clk),
         .rst   (rst),
         .i_clr (r_clr),
         .i_en  (w_shift),
         .i_d   (r_a[k]),
         .o_q   (w_a_out[k])
      );
   end
`else
   assign w_a_out = r_a;
`endif

   assign a0          = w_a_out[0];
   assign a1          = w_a_out[1];
   assign a2          = w_a_out[2];
   assign a3          = w_a_out[3];
   assign a4          = w_a_out[4];
   assign a5          = w_a_out[5];
   assign en          = r_en;
   assign clr         = r_clr;
   assign busy        = (r_state != IDLE);
   assign batch_done  = r_done;
   assign beat_cnt    = r_beat_cnt;
   assign err_overlen = r_err;

endmodule : systolic_6x6_feeder

`default_nettype wire

// File: tb/tb_systolic_6x6_feeder.sv
// =============================================================================
//  Module      : tb_systolic_6x6_feeder
//  Description : Self-checking bench for systolic_6x6_feeder. Three instances
//                (MAX_LEN 16, 4, 1) share the stream inputs; only the selected
//                one sees s_valid. Expected array drive events are queued as
//                beats are handed over and retired by a negedge monitor.
//                Honours SYSTOLIC_FEEDER_SKEW_EN for the lane-skew build.
//  Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_systolic_6x6_feeder;
   import systolic_pkg::*;

   localparam int W    = 16;
   localparam int F    = 14;
   localparam int NDUT = 3;
`ifdef SYSTOLIC_FEEDER_SKEW_EN
   localparam int SKEW = 1;
`else
   localparam int SKEW = 0;
`endif

   localparam logic [1:0] EV_CLR  = 2'd0;
   localparam logic [1:0] EV_EN   = 2'd1;
   localparam logic [1:0] EV_DONE = 2'd2;

   typedef struct packed {
      logic [1:0]          kind;
      logic [5:0][W-1:0]   d;
   } ev_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_last;
   logic [6*W-1:0] s_data;
   int            sel;

   logic          sv     [NDUT];
   logic          rdy    [NDUT];
   logic          en_o   [NDUT];
   logic          clr_o  [NDUT];
   logic          busy_o [NDUT];
   logic          done_o [NDUT];
   logic          err_o  [NDUT];
   logic [7:0]    cnt_o  [NDUT];
   logic [W-1:0]  a_o    [NDUT][6];

   always #5 clk = ~clk;

   for (genvar i = 0; i < NDUT; i++) begin : g_dut
      localparam int ML = (i == 0) ? 16 : ((i == 1) ? 4 : 1);
      assign sv[i] = s_valid && (sel == i);
      systolic_6x6_feeder #(
         .WIDTH        (W),
         .FLUSH_CYCLES (F),
         .MAX_LEN      (ML)
      ) u_dut (
         .clk         (clk),
         .rst         (rst),
         .s_valid     (sv[i]),
         .s_ready     (rdy[i]),
         .s_last      (s_last),
         .s_data      (s_data),
         .a0          (a_o[i][0]),
         .a1          (a_o[i][1]),
         .a2          (a_o[i][2]),
         .a3          (a_o[i][3]),
         .a4          (a_o[i][4]),
         .a5          (a_o[i][5]),
         .en          (en_o[i]),
         .clr         (clr_o[i]),
         .busy        (busy_o[i]),
         .batch_done  (done_o[i]),
         .beat_cnt    (cnt_o[i]),
         .err_overlen (err_o[i])
      );
   end

   int   n_assert = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   en_cnt   = 0;
   ev_t  q[$];

   // model state of the driver side
   bit   m_idle = 1'b1;
   int   m_cnt  = 0;
   int   m_max  = 16;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [5:0][W-1:0] hist [6];
   logic [5:0][W-1:0] prev;

   always @(negedge clk) begin
      ev_t e;
      logic [5:0][W-1:0] expv;
      cyc++;
      if (rst !== 1'b0) begin
         for (int j = 0; j < 6; j++) hist[j] = '0;
         prev = '0;
      end else begin
         chk("clr_en_exclusive", {63'd0, clr_o[sel] & en_o[sel]}, 64'd0);
         if (en_o[sel] === 1'b1) en_cnt++;
         if ((clr_o[sel] | en_o[sel] | done_o[sel]) === 1'b1) begin
            chk("unexpected_output", {63'd0, q.size() != 0}, 64'd1);
            if (q.size() != 0) begin
               e = q.pop_front();
               chk("clr", {63'd0, clr_o[sel]},  {63'd0, e.kind == EV_CLR});
               chk("en",  {63'd0, en_o[sel]},   {63'd0, e.kind == EV_EN});
               chk("done",{63'd0, done_o[sel]}, {63'd0, e.kind == EV_DONE});
               expv = '0;
               if (e.kind == EV_CLR) begin
                  for (int j = 0; j < 6; j++) hist[j] = '0;
               end else if (e.kind == EV_EN) begin
                  for (int j = 5; j > 0; j--) hist[j] = hist[j-1];
                  hist[0] = e.d;
                  for (int k = 0; k < 6; k++) expv[k] = hist[k*SKEW][k];
               end
               prev = expv;
            end
         end
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("lane%0d", k), {48'd0, a_o[sel][k]}, {48'd0, prev[k]});
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic drive_beat(input logic [6*W-1:0] d, input bit last);
      int n = 0;
      ev_t e;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      if (m_idle) begin
         e.kind = EV_CLR; e.d = '0; q.push_back(e);
         m_idle = 1'b0;
         m_cnt  = 0;
      end
      while (rdy[sel] !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("ready_timeout", {63'd0, n < 100}, 64'd1);
      e.kind = EV_EN; e.d = d; q.push_back(e);
      m_cnt++;
      if (last || m_cnt == m_max) begin
         for (int i = 0; i < F + 5*SKEW; i++) begin
            e.kind = EV_EN; e.d = '0; q.push_back(e);
         end
         e.kind = EV_DONE; e.d = '0; q.push_back(e);
         m_idle = 1'b1;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk); #1; n++;
      end
      chk("drain_timeout", {63'd0, q.size() == 0}, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   logic [6*W-1:0] beats [5];
   int t0, len1, len2;

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; sel = 0;
      beats[0] = {16'h0000, 16'hFACC, 16'hFACC, 16'h06CC, 16'h0533, 16'hFB33};
      for (int b = 1; b < 5; b++) begin
         beats[b] = {$urandom, $urandom, $urandom};
      end
      wait_cycles(3);
      rst = 1'b0;
      @(negedge clk); #1;
      chk("rst_en",    {63'd0, en_o[0]},   64'd0);
      chk("rst_clr",   {63'd0, clr_o[0]},  64'd0);
      chk("rst_busy",  {63'd0, busy_o[0]}, 64'd0);
      chk("rst_done",  {63'd0, done_o[0]}, 64'd0);
      chk("rst_err",   {63'd0, err_o[0]},  64'd0);
      chk("rst_ready", {63'd0, rdy[0]},    64'd0);
      chk("rst_cnt",   {56'd0, cnt_o[0]},  64'd0);
      @(posedge clk); #1;

      // 1: five continuous beats
      m_max = 16;
      t0 = cyc;
      for (int b = 0; b < 5; b++) drive_beat(beats[b], b == 4);
      drain();
      len1 = cyc - t0;
      chk("s1_beat_cnt", {56'd0, cnt_o[0]}, 64'd5);
      chk("s1_err",      {63'd0, err_o[0]}, 64'd0);
      chk("s1_busy",     {63'd0, busy_o[0]}, 64'd0);

      // 2: same batch with two bubble cycles after the first beat
      t0 = cyc;
      drive_beat(beats[0], 1'b0);
      wait_cycles(2);
      for (int b = 1; b < 5; b++) drive_beat(beats[b], b == 4);
      drain();
      len2 = cyc - t0;
      chk("s2_beat_cnt", {56'd0, cnt_o[0]}, 64'd5);
      chk("s2_two_cycle_delay", 64'(len2), 64'(len1 + 2));

      // 3: MAX_LEN=4, six beats, s_last only on the sixth
      sel = 1; m_max = 4;
      for (int b = 0; b < 6; b++) begin
         drive_beat({$urandom, $urandom, $urandom}, b == 5);
         if (b == 3) chk("s3_err_after_beat4", {63'd0, err_o[1]}, 64'd1);
      end
      drain();
      chk("s3_err_sticky", {63'd0, err_o[1]}, 64'd1);
      chk("s3_beat_cnt",   {56'd0, cnt_o[1]}, 64'd2);

      // 4: reset during FLUSH
      sel = 0; m_max = 16;
      drive_beat(beats[1], 1'b0);
      drive_beat(beats[2], 1'b1);
      wait_cycles(3);
      chk("s4_in_flush_en", {63'd0, en_o[0]}, 64'd1);
      rst = 1'b1;
      q.delete();
      m_idle = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk); #1;
      chk("s4_en",      {63'd0, en_o[0]},   64'd0);
      chk("s4_busy",    {63'd0, busy_o[0]}, 64'd0);
      chk("s4_done",    {63'd0, done_o[0]}, 64'd0);
      chk("s4_err_dut1",{63'd0, err_o[1]},  64'd0);
      chk("s4_cnt",     {56'd0, cnt_o[0]},  64'd0);
      wait_cycles(4);
      drive_beat(beats[3], 1'b1);
      drain();
      chk("s4_restart_cnt", {56'd0, cnt_o[0]}, 64'd1);

      // 5/6: MAX_LEN=1, single beat of 0x0400 in every lane
      sel = 2; m_max = 1;
      en_cnt = 0;
      drive_beat({6{16'h0400}}, 1'b1);
      drain();
      chk("s6_err",      {63'd0, err_o[2]}, 64'd0);
      chk("s6_beat_cnt", {56'd0, cnt_o[2]}, 64'd1);
      chk("s6_en_cycles", 64'(en_cnt), 64'(1 + F + 5*SKEW));
      drive_beat({6{16'h0400}}, 1'b0);
      drain();
      chk("s6_overlen_err", {63'd0, err_o[2]}, 64'd1);
      chk("s6_overlen_cnt", {56'd0, cnt_o[2]}, 64'd1);

      wait_cycles(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_systolic_6x6_feeder

`default_nettype wire

// File: doc/systolic_6x6_feeder.md
Name: systolic_6x6_feeder

Overview:
Stream-side transmitter for the 6x6 systolic array. It accepts activation vectors (6 lanes, Q6.10) over a valid/ready stream and produces the array's per-cycle drive signals: a0..a5, en and clr. Each batch starts with a one-cycle clear and ends with a fixed zero flush that drains the array, replacing hand-sequenced stimulus with a reusable block.

Parameters:
WIDTH, 16, lane word width (signed Q6.10).
FLUSH_CYCLES, 14, zero-vector cycles with en=1 driven after the last beat; range 1..255.
MAX_LEN, 16, maximum beats per batch; range 1..255.

Ports:
clk  in  1  clock, all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
s_valid  in  1  input beat valid.
s_ready  out  1  input beat ready; combinational, equals (state==STREAM).
s_last  in  1  marks the final beat of a batch.
s_data  in  6*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
a0..a5  out  WIDTH each  array activation inputs (registered).
en  out  1  array enable (registered).
clr  out  1  array accumulator clear (registered).
busy  out  1  high in any state except IDLE.
batch_done  out  1  one-cycle pulse at the end of a batch.
beat_cnt  out  8  beats accepted in the current or last batch.
err_overlen  out  1  sticky; set when MAX_LEN is reached without s_last.

Behaviour:
- Reset: all outputs are 0 and state is IDLE. err_overlen and beat_cnt clear to 0. Reset asserted mid-batch aborts the batch on the next edge with no batch_done.
- FSM: IDLE -> CLEAR -> STREAM -> FLUSH -> DONE -> IDLE.
- IDLE: s_ready=0, en=0, a*=0. If s_valid=1, go to CLEAR; the beat is held, not consumed.
- CLEAR: registers clr=1, en=0 for exactly one cycle. beat_cnt<=0. Go to STREAM.
- STREAM:
  - Accepted beat (s_valid & s_ready): the next cycle shows a_k=lane k and en=1, giving 1-cycle latency. beat_cnt increments.
  - Bubble (s_valid=0): en=0 and a* hold their previous values, so the array freezes.
  - Accepted beat with s_last=1: go to FLUSH.
  - Accepted beat that makes beat_cnt==MAX_LEN with s_last=0: set err_overlen and go to FLUSH. Following beats start a new batch.
  - s_last and MAX_LEN reached on the same beat: normal termination, no error.
- FLUSH: a*=0, en=1 for FLUSH_CYCLES cycles, counted by an internal down-counter. s_ready=0. Go to DONE.
- DONE: batch_done=1 and en=0 for one cycle; a* return to 0. Go to IDLE. beat_cnt holds until the next CLEAR.
- clr and en are never high in the same cycle.
- No arithmetic on data; words pass bit-exact, with no saturation or rounding.
- Minimum batch cost = 1 (CLEAR) + N beats + FLUSH_CYCLES + 1 (DONE) cycles, excluding bubbles.

Optional Feature:
Macro: SYSTOLIC_FEEDER_SKEW_EN.
- Defined:
  - Lane k passes through k extra registers, so a0 is undelayed and a5 is delayed by 5. This produces the diagonal wavefront required by an unskewed-input array variant.
  - Skew registers shift only when en=1 and clear to 0 on clr or rst.
  - FLUSH runs FLUSH_CYCLES+5 cycles so lane 5 drains fully.
- Undefined: all lanes are aligned (1-cycle latency), FLUSH runs FLUSH_CYCLES, and no skew registers exist.

Decomposition:
- Package systolic_pkg holds:
  - WIDTH=16, FRAC_BIT=10, LANES=6.
  - Typedef for the feeder FSM state enum (IDLE, CLEAR, STREAM, FLUSH, DONE).
  - Typedef for the packed lane vector.
- Sub-module: systolic_lane_delay (parameter DEPTH, enable-gated shift register with sync clear). It is instantiated per lane only under SYSTOLIC_FEEDER_SKEW_EN.

Test Plan:
1. Batch of 5 beats, continuous s_valid, last beat s_last=1. Beat 0 lanes = FB33, 0533, 06CC, FACC, FACC, 0000.
   - clr=1 for 1 cycle, then 5 cycles with en=1 and a0..a5 matching each beat.
   - Then 14 zero cycles with en=1, then batch_done=1 once; beat_cnt=5.
2. Same batch with s_valid=0 on cycles 2-3 of STREAM.
   - en=0 with a* held during the bubbles; the sequence otherwise matches scenario 1, delayed by 2 cycles.
3. MAX_LEN=4, send 6 beats with s_last only on beat 6.
   - err_overlen=1 after beat 4, then FLUSH and batch_done.
   - Beats 5-6 form a second batch with its own clr, and beat_cnt=2.
4. rst=1 for one cycle during FLUSH.
   - Next cycle: en=0, a*=0, busy=0, no batch_done, err_overlen=0. A new s_valid starts cleanly with clr.
5. With SYSTOLIC_FEEDER_SKEW_EN, send a single beat with all lanes=0400 and s_last=1.
   - a_k shows 0400 exactly k cycles after a0 does.
   - Total en=1 cycles = 1+14+5 = 20.
6. Single-beat batch with s_last=1 (MAX_LEN=1).
   - No err_overlen; beat_cnt=1; clr and en never asserted together.
